mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 The block SHALL have parameter addr_size, default 16, RAM word-address width.
REQ-002 The block SHALL have parameter data_size, default 16, RAM word width; even values only; half-word ("byte") = data_size/2 bits.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 The block SHALL have port req_valid  input  1  request present.
REQ-006 The block SHALL have port req_ready  output  1  block accepts request this cycle.
REQ-007 The block SHALL have port req_op  input  2  00 load word, 01 store word, 10 load byte (zero-extend), 11 store byte.
REQ-008 The block SHALL have port req_addr  input  addr_size  word address.
REQ-009 The block SHALL have port req_hi  input  1  byte ops only: 1 = upper half, 0 = lower half.
REQ-010 The block SHALL have port req_wdata  input  data_size  store data; store byte uses bits [data_size/2-1:0].
REQ-011 The block SHALL have port resp_valid  output  1  response present.
REQ-012 The block SHALL have port resp_ready  input  1  consumer accepts response.
REQ-013 The block SHALL have port resp_data  output  data_size  loads: read value; stores: full word written.
REQ-014 The block SHALL have ports ram_wenable (output, 1), ram_waddr (output, addr_size), ram_wdata (output, data_size): downstream RAM write port; the RAM commits on the falling edge of the cycle in which ram_wenable is high.
REQ-015 The block SHALL have ports ram_raddr (output, addr_size) and ram_rdata (input, data_size): downstream RAM read port; combinational read, same-cycle data.

Function
REQ-016 The block SHALL implement FSM states IDLE, EXEC, RESP.
REQ-017 IDLE: req_ready=1; on req_valid the block SHALL latch op/addr/hi/wdata and go to EXEC.
REQ-018 EXEC: req_ready=0; ram_raddr=latched addr; next state RESP (always, exactly one cycle).
REQ-019 EXEC load word: resp_data register SHALL capture ram_rdata.
REQ-020 EXEC load byte: resp_data SHALL capture the selected half of ram_rdata, zero-extended; upper bits 0.
REQ-021 EXEC store word: ram_wenable=1, ram_waddr=latched addr, ram_wdata=latched wdata; resp_data captures latched wdata.
REQ-022 EXEC store byte: ram_wdata SHALL be ram_rdata with the selected half replaced by wdata[data_size/2-1:0], other half unchanged; ram_wenable=1; resp_data captures the merged word.
REQ-023 ram_wenable SHALL be 0 in every state other than EXEC-with-store, and 0 whenever rst=1.
REQ-024 RESP: resp_valid=1; resp_data stable until handshake (resp_valid&&resp_ready).
REQ-025 RESP, no handshake: the block SHALL stay in RESP, req_ready=0.
REQ-026 RESP, handshake, req_valid=0: go to IDLE.
REQ-027 RESP, handshake, req_valid=1: req_ready=1 (combinational on resp_ready); the block SHALL latch the new request and go directly to EXEC (back-to-back, one request per 2 cycles).
REQ-028 Latency: request accepted at edge N -> RAM access in cycle N..N+1 -> resp_valid=1 after edge N+1.
REQ-029 A load following a store to the same address SHALL return the stored value (store commits on falling edge of its EXEC cycle, before the load's EXEC).
REQ-030 Address wrap: none; addresses beyond range are not possible by width; all 2^addr_size words are legal.

Reset
REQ-031 While rst=1 at a rising edge: state->IDLE, resp_valid=0, resp_data=0, latched request cleared to 0.
REQ-032 Reset in EXEC: no RAM write in that cycle (REQ-023); no response is produced for the aborted request.
REQ-033 Reset in RESP: pending response discarded; resp_valid=0 after the edge.
REQ-034 The first request SHALL be accepted in the first cycle with rst=0.

Verification
REQ-035 Store word addr 0x0010 data 0xBEEF, then load word 0x0010 -> store resp_data=0xBEEF, load resp_data=0xBEEF, each resp_valid 2 cycles after accept.
REQ-036 RAM[0x0020]=0x1234; store byte hi=1 data 0x00AB -> RAM[0x0020]=0xAB34, resp_data=0xAB34; load byte hi=0 -> resp_data=0x0034.
REQ-037 Hold resp_ready=0 for 5 cycles in RESP -> resp_valid and resp_data stable, req_ready=0, ram_wenable=0 throughout.
REQ-038 Continuous req_valid with resp_ready=1, 4 loads -> one accept every 2 cycles, responses in order with correct data.
REQ-039 Assert rst in the EXEC cycle of store 0x5555 to 0x0030 (old 0x0000) -> RAM[0x0030] stays 0x0000, resp_valid=0, state IDLE next cycle.

Source files
------------

// File: rtl/mem_access.sv
// Single-port-style memory access sequencer.
// Runs word and half-word loads and stores against an external RAM.
// A half-word store is a read-modify-write that completes in one cycle.
//
// state | meaning
// IDLE  | ready for a request; req_ready=1
// EXEC  | RAM access cycle for the latched request; the write happens here for stores
// RESP  | response held until resp_ready; a new request may be taken on handshake
module mem_access #(
    parameter int addr_size = 16,
    parameter int data_size = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [addr_size-1:0] req_addr,
    input  logic                 req_hi,
    input  logic [data_size-1:0] req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [data_size-1:0] resp_data,
    output logic                 ram_wenable,
    output logic [addr_size-1:0] ram_waddr,
    output logic [data_size-1:0] ram_wdata,
    output logic [addr_size-1:0] ram_raddr,
    input  logic [data_size-1:0] ram_rdata
);

    localparam int half = data_size / 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_next;

    // Latched request. op[0] = store, op[1] = half-word access.
    logic [1:0]           op_q;
    logic [addr_size-1:0] addr_q;
    logic                 hi_q;
    logic [data_size-1:0] wdata_q;
    logic [data_size-1:0] resp_data_q;

    logic                 accept;
    logic [data_size-1:0] merged;
    logic [data_size-1:0] load_half;
    logic [data_size-1:0] exec_result;

    // Request handshake and next-state decode.
    always_comb begin
        req_ready  = 1'b0;
        state_next = state;
        unique case (state)
            IDLE: req_ready = 1'b1;
            EXEC: req_ready = 1'b0;
            RESP: req_ready = resp_ready;
            default: req_ready = 1'b0;
        endcase
        accept = req_valid && req_ready;
        unique case (state)
            IDLE: if (accept) state_next = EXEC;
            EXEC: state_next = RESP;
            RESP: if (resp_ready) state_next = accept ? EXEC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Half-word merge for byte stores and half-word select for byte loads.
    always_comb begin
        merged      = ram_rdata;
        load_half   = '0;
        exec_result = ram_rdata;
        if (hi_q) begin
            merged    = {wdata_q[half-1:0], ram_rdata[half-1:0]};
            load_half = {{half{1'b0}}, ram_rdata[data_size-1:half]};
        end else begin
            merged    = {ram_rdata[data_size-1:half], wdata_q[half-1:0]};
            load_half = {{half{1'b0}}, ram_rdata[half-1:0]};
        end
        unique case (op_q)
            2'b00: exec_result = ram_rdata;
            2'b01: exec_result = wdata_q;
            2'b10: exec_result = load_half;
            2'b11: exec_result = merged;
            default: exec_result = ram_rdata;
        endcase
    end

    // RAM port drive; the write strobe is gated by rst so an aborted store never lands.
    always_comb begin
        ram_raddr   = addr_q;
        ram_waddr   = addr_q;
        ram_wdata   = op_q[1] ? merged : wdata_q;
        ram_wenable = (state == EXEC) && op_q[0] && !rst;
        resp_valid  = (state == RESP);
        resp_data   = resp_data_q;
    end

    // State register, request latch and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            hi_q        <= 1'b0;
            wdata_q     <= '0;
            resp_data_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= req_addr;
                hi_q    <= req_hi;
                wdata_q <= req_wdata;
            end
            if (state == EXEC) begin
                resp_data_q <= exec_result;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a RAM model and an expected-response queue.
module tb_mem_access;

    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_addr = '0;
    logic          req_hi = 1'b0;
    logic [DW-1:0] req_wdata = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [DW-1:0] resp_data;
    logic          ram_wenable;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem    [0:65535];
    logic [DW-1:0] shadow [0:65535];
    logic [DW-1:0] exp_q  [$];

    int n_checks = 0;
    int n_err    = 0;

    mem_access #(.addr_size(AW), .data_size(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_hi(req_hi), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .ram_wenable(ram_wenable), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // RAM: combinational read, write commits on the falling edge.
    assign ram_rdata = mem[ram_raddr];
    always @(negedge clk) if (ram_wenable) mem[ram_waddr] <= ram_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one request against the shadow memory.
    task automatic predict(input logic [1:0] op, input logic [15:0] addr, input logic hi,
                           input logic [15:0] wd, output logic [15:0] r);
        logic [15:0] w;
        w = shadow[addr];
        case (op)
            2'b00: r = w;
            2'b01: begin r = wd; shadow[addr] = wd; end
            2'b10: r = hi ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
            default: begin
                r = hi ? {wd[7:0], w[7:0]} : {w[15:8], wd[7:0]};
                shadow[addr] = r;
            end
        endcase
    endtask

    // Present a request and return just after the accepting edge.
    task automatic send(input logic [1:0] op, input logic [15:0] addr, input logic hi,
                        input logic [15:0] wd, input bit model_it, output int waits);
        logic [15:0] r;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_hi = hi; req_wdata = wd;
        waits = 0;
        @(negedge clk);
        while (!req_ready && waits < 20) begin
            waits++;
            @(negedge clk);
        end
        if (!req_ready) check("accept_timeout", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        if (model_it) begin
            predict(op, addr, hi, wd, r);
            exp_q.push_back(r);
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        logic [15:0] e;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check(tag, {16'd0, resp_data}, {16'd0, e});
    endtask

    // Full transaction with resp_ready high; checks the 2-cycle latency.
    task automatic xact(input string tag, input logic [1:0] op, input logic [15:0] addr,
                        input logic hi, input logic [15:0] wd, output int waits);
        resp_ready = 1'b1;
        send(op, addr, hi, wd, 1'b1, waits);
        @(negedge clk);
        check({tag, "_exec_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_exec_wen"}, {31'd0, ram_wenable}, {31'd0, op[0]});
        check({tag, "_exec_raddr"}, {16'd0, ram_raddr}, {16'd0, addr});
        @(negedge clk);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        pop_check({tag, "_data"});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int idx, cyc, last_acc, got;
        bit acc;
        logic [15:0] r;
        logic [15:0] b2b_addr [4];

        for (int i = 0; i < 65536; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        mem[16'h0020] = 16'h1234; shadow[16'h0020] = 16'h1234;
        mem[16'h0040] = 16'h4444; shadow[16'h0040] = 16'h4444;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_data", {16'd0, resp_data}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_wen", {31'd0, ram_wenable}, 32'd0);

        // First request in first cycle out of reset; store then load same word
        @(posedge clk);
        #1 rst = 1'b0;
        xact("st_word", 2'b01, 16'h0010, 1'b0, 16'hBEEF, w);
        check("first_accept_wait", w, 0);
        check("mem_0010", {16'd0, mem[16'h0010]}, 32'h0000BEEF);
        xact("ld_word", 2'b00, 16'h0010, 1'b0, 16'h0000, w);

        // Half-word operations
        xact("st_byte_hi", 2'b11, 16'h0020, 1'b1, 16'h00AB, w);
        check("mem_0020_hi", {16'd0, mem[16'h0020]}, 32'h0000AB34);
        xact("ld_byte_lo", 2'b10, 16'h0020, 1'b0, 16'h0000, w);
        xact("ld_byte_hi", 2'b10, 16'h0020, 1'b1, 16'h0000, w);
        xact("st_byte_lo", 2'b11, 16'h0020, 1'b0, 16'hFFCD, w);
        check("mem_0020_lo", {16'd0, mem[16'h0020]}, 32'h0000ABCD);
        xact("ld_word_20", 2'b00, 16'h0020, 1'b0, 16'h0000, w);
        xact("st_word_ffff", 2'b01, 16'hFFFF, 1'b0, 16'h7E81, w);
        xact("ld_word_ffff", 2'b00, 16'hFFFF, 1'b0, 16'h0000, w);

        // Response back-pressure
        resp_ready = 1'b0;
        send(2'b00, 16'h0010, 1'b0, 16'h0000, 1'b1, w);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check("stall_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_data", {16'd0, resp_data}, {16'd0, exp_q[0]});
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            check("stall_wen", {31'd0, ram_wenable}, 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        pop_check("stall_release_data");
        @(posedge clk);
        #1;

        // Back-to-back loads
        b2b_addr[0] = 16'h0010; b2b_addr[1] = 16'h0020;
        b2b_addr[2] = 16'h0040; b2b_addr[3] = 16'hFFFF;
        idx = 0; cyc = 0; last_acc = -1; got = 0;
        resp_ready = 1'b1;
        req_valid = 1'b1; req_op = 2'b00; req_hi = 1'b0; req_wdata = '0;
        req_addr = b2b_addr[0];
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            if (resp_valid) begin
                pop_check("b2b_data");
                got++;
            end
            @(posedge clk);
            if (acc) begin
                predict(2'b00, req_addr, 1'b0, 16'h0000, r);
                exp_q.push_back(r);
                if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, 2);
                last_acc = cyc;
                idx++;
            end
            #1;
            if (idx < 4) req_addr = b2b_addr[idx];
            else req_valid = 1'b0;
            cyc++;
        end
        check("b2b_count", got, 4);

        // Reset while a response is pending
        resp_ready = 1'b0;
        send(2'b00, 16'h0020, 1'b0, 16'h0000, 1'b1, w);
        @(negedge clk);
        @(negedge clk);
        check("rresp_valid_before", {31'd0, resp_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rresp_valid_after", {31'd0, resp_valid}, 32'd0);
        check("rresp_idle", {31'd0, req_ready}, 32'd1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        resp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset during the EXEC cycle of a store
        send(2'b01, 16'h0030, 1'b0, 16'h5555, 1'b0, w);
        rst = 1'b1;
        @(negedge clk);
        check("rexec_wen", {31'd0, ram_wenable}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rexec_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rexec_idle", {31'd0, req_ready}, 32'd1);
        check("rexec_resp_data", {16'd0, resp_data}, 32'd0);
        check("rexec_mem_0030", {16'd0, mem[16'h0030]}, 32'd0);
        @(posedge clk);
        #1;
        xact("ld_after_abort", 2'b00, 16'h0030, 1'b0, 16'h0000, w);
        check("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
